// File: rtl/pc_next_predictor.sv
// Next-PC predictor for the fetch stage: direct-mapped BTB with 2-bit saturating
// counters, looked up combinationally and trained by EX-stage redirects.
module pc_next_predictor #(
   parameter int WORD_SIZE = 16,
   parameter int IDX_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] PC,
   input  logic [WORD_SIZE-1:0] instruction,
   output logic [WORD_SIZE-1:0] nextPC,
   input  logic                 forcePC,
   input  logic [WORD_SIZE-1:0] forcePCdata,
   input  logic [WORD_SIZE-1:0] EX_PC
);

   localparam int unsigned ENTRIES  = 1 << IDX_BITS;
   localparam int          TAG_BITS = WORD_SIZE - IDX_BITS;

   // Counters are stored XOR 2'b01 so an all-zero power-up image reads as the
   // reset state (ctr = 1, weakly not-taken) without any initialisation.
   localparam logic [1:0] CTR_ENC = 2'b01;

   logic                 btb_valid   [ENTRIES];
   logic [TAG_BITS-1:0]  btb_tag     [ENTRIES];
   logic [WORD_SIZE-1:0] btb_target  [ENTRIES];
   logic [1:0]           btb_ctr_enc [ENTRIES];

   logic [IDX_BITS-1:0]  rd_idx;
   logic [TAG_BITS-1:0]  rd_tag;
   logic                 rd_hit;
   logic [1:0]           rd_ctr;
   logic [WORD_SIZE-1:0] pc_inc;

   logic [IDX_BITS-1:0]  wr_idx;
   logic [TAG_BITS-1:0]  wr_tag;
   logic                 wr_hit;
   logic [1:0]           wr_ctr;
   logic [1:0]           wr_ctr_nxt;
   logic [WORD_SIZE-1:0] ex_pc_inc;
   logic                 ex_taken;

   logic                 unused_instruction;

   assign unused_instruction = ^instruction;

   always_comb begin
      rd_idx = PC[IDX_BITS-1:0];
      rd_tag = PC[WORD_SIZE-1:IDX_BITS];
      pc_inc = PC + WORD_SIZE'(1);
      rd_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
      rd_ctr = btb_ctr_enc[rd_idx] ^ CTR_ENC;
      nextPC = (rd_hit && rd_ctr[1]) ? btb_target[rd_idx] : pc_inc;
   end

   always_comb begin
      wr_idx    = EX_PC[IDX_BITS-1:0];
      wr_tag    = EX_PC[WORD_SIZE-1:IDX_BITS];
      ex_pc_inc = EX_PC + WORD_SIZE'(1);
      ex_taken  = (forcePCdata != ex_pc_inc);
      wr_hit    = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
      wr_ctr    = btb_ctr_enc[wr_idx] ^ CTR_ENC;
   end

   always_comb begin
      wr_ctr_nxt = wr_ctr;
      if (!ex_taken) begin
         if (wr_ctr != 2'd0)
            wr_ctr_nxt = wr_ctr - 2'd1;
      end else if (!wr_hit) begin
         wr_ctr_nxt = 2'd2;
      end else if (wr_ctr != 2'd3) begin
         wr_ctr_nxt = wr_ctr + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            btb_valid[IDX_BITS'(i)]   <= 1'b0;
            btb_ctr_enc[IDX_BITS'(i)] <= 2'd1 ^ CTR_ENC;
         end
      end else if (forcePC) begin
         if (ex_taken) begin
            btb_valid[wr_idx]   <= 1'b1;
            btb_tag[wr_idx]     <= wr_tag;
            btb_target[wr_idx]  <= forcePCdata;
            btb_ctr_enc[wr_idx] <= wr_ctr_nxt ^ CTR_ENC;
         end else if (wr_hit) begin
            btb_ctr_enc[wr_idx] <= wr_ctr_nxt ^ CTR_ENC;
         end
      end
   end

endmodule

// File: tb/tb_pc_next_predictor.sv
// Directed scoreboard bench for pc_next_predictor: stimulus queues expected
// nextPC values, a negedge monitor pops and compares them.
module tb_pc_next_predictor;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] PC = '0;
   logic [15:0] instruction = '0;
   logic [15:0] nextPC;
   logic        forcePC = 1'b0;
   logic [15:0] forcePCdata = '0;
   logic [15:0] EX_PC = '0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   pc_next_predictor #(.WORD_SIZE(16), .IDX_BITS(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .PC          (PC),
      .instruction (instruction),
      .nextPC      (nextPC),
      .forcePC     (forcePC),
      .forcePCdata (forcePCdata),
      .EX_PC       (EX_PC)
   );

   always #5 clk = ~clk;

   // Monitor: one expectation per cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (PC !== e.pc || nextPC !== e.exp) begin
            n_fail++;
            $display("FAIL %s: PC=%h nextPC=%h, required PC=%h nextPC=%h",
                     e.name, PC, nextPC, e.pc, e.exp);
         end
      end
   end

   // Drive one cycle of inputs (applied just after a posedge) and queue the
   // nextPC expected for that cycle.
   task automatic step(input string name, input logic [15:0] pc, input logic [15:0] exp,
                       input logic f = 1'b0, input logic [15:0] ex = 16'h0,
                       input logic [15:0] fd = 16'h0, input logic rn = 1'b1);
      exp_t e;
      PC          = pc;
      instruction = pc ^ 16'hA5A5;
      forcePC     = f;
      EX_PC       = ex;
      forcePCdata = fd;
      reset_n     = rn;
      e.pc = pc; e.exp = exp; e.name = name;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;

      // Reset state and wrap
      step("rst_pc5",    16'h0005, 16'h0006);
      step("rst_wrap",   16'hFFFF, 16'h0000);
      step("rst_pc10",   16'h0010, 16'h0011);

      // Allocate 0x10 -> 0x40 (ctr 2)
      step("alloc_cyc",  16'h0010, 16'h0011, 1'b1, 16'h0010, 16'h0040);
      step("alloc_hit",  16'h0010, 16'h0040);

      // Not-taken -> ctr 1
      step("nt_cyc",     16'h0005, 16'h0006, 1'b1, 16'h0010, 16'h0011);
      step("nt_ctr1",    16'h0010, 16'h0011);

      // Two taken to 0x50 -> ctr 2 then 3
      step("tk1_cyc",    16'h0010, 16'h0011, 1'b1, 16'h0010, 16'h0050);
      step("tk1_ctr2",   16'h0010, 16'h0050, 1'b1, 16'h0010, 16'h0050);
      step("tk2_ctr3",   16'h0010, 16'h0050, 1'b1, 16'h0010, 16'h0050);
      // Third taken saturates at 3; one not-taken leaves 2 (still taken)
      step("sat3_nt",    16'h0010, 16'h0050, 1'b1, 16'h0010, 16'h0011);
      step("sat3_ctr2",  16'h0010, 16'h0050, 1'b1, 16'h0010, 16'h0050);
      step("back_ctr3",  16'h0010, 16'h0050);

      // Alias: same index, different tag
      step("alias_miss", 16'h0110, 16'h0111, 1'b1, 16'h0110, 16'h0200);
      step("alias_old",  16'h0010, 16'h0011);
      step("alias_new",  16'h0110, 16'h0200);

      // Same-cycle update is not visible until after the edge
      step("same_cyc",   16'h0020, 16'h0021, 1'b1, 16'h0020, 16'h0030);
      step("same_after", 16'h0020, 16'h0030);

      // Decrement saturates at 0: 2 -> 1 -> 0 -> 0, then taken -> 1, -> 2
      step("dec1",       16'h0020, 16'h0030, 1'b1, 16'h0020, 16'h0021);
      step("dec2",       16'h0020, 16'h0021, 1'b1, 16'h0020, 16'h0021);
      step("dec3",       16'h0020, 16'h0021, 1'b1, 16'h0020, 16'h0021);
      step("inc_from0",  16'h0020, 16'h0021, 1'b1, 16'h0020, 16'h0035);
      step("ctr1_still", 16'h0020, 16'h0021, 1'b1, 16'h0020, 16'h0035);
      step("ctr2_taken", 16'h0020, 16'h0035);

      // Not-taken redirect on a missing entry changes nothing
      step("nt_miss",    16'h0030, 16'h0031, 1'b1, 16'h0030, 16'h0031);
      step("nt_miss_chk",16'h0030, 16'h0031);

      // Taken redirect whose target wraps: EX_PC=FFFF, data 0 is not-taken
      step("wrap_nt",    16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000);
      step("wrap_nt_chk",16'hFFFF, 16'h0000);

      // Reset with simultaneous forcePC: reset wins
      step("rst_force",  16'h0110, 16'h0200, 1'b1, 16'h0040, 16'h0080, 1'b0);
      step("post_rst10", 16'h0010, 16'h0011);
      step("post_rst110",16'h0110, 16'h0111);
      step("post_rst20", 16'h0020, 16'h0021);
      step("post_rst40", 16'h0040, 16'h0041);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_next_predictor.md
Name: pc_next_predictor

Overview:
- Next-PC predictor for the instruction-fetch stage of a 5-stage pipelined CPU with data forwarding.
- Given the current fetch PC, combinationally produces the predicted next fetch PC.
- Uses a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Trained by EX-stage redirects (forcePC), which occur only on a misprediction.

Parameters:
- WORD_SIZE, 16, width of PC, instruction and all address ports.
- IDX_BITS, 8, BTB index width; BTB has 2^IDX_BITS entries indexed by PC[IDX_BITS-1:0].

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- PC  input  WORD_SIZE  current fetch PC; already equals forcePCdata when forcePC=1.
- instruction  input  WORD_SIZE  fetched instruction; reserved; ignored by this block.
- nextPC  output  WORD_SIZE  predicted next fetch PC; combinational.
- forcePC  input  1  EX-stage redirect; asserted for one cycle per misprediction.
- forcePCdata  input  WORD_SIZE  correct successor PC of the instruction at EX_PC.
- EX_PC  input  WORD_SIZE  PC of the instruction resolved in EX.

Behaviour:
- BTB entry fields: valid (1), tag (PC[WORD_SIZE-1:IDX_BITS]), target (WORD_SIZE), ctr (2-bit saturating).
- Lookup is combinational, using index = PC[IDX_BITS-1:0].
  - hit = valid && tag match.
  - nextPC = target if hit && ctr >= 2.
  - Otherwise nextPC = PC + 1, modulo 2^WORD_SIZE; 16'hFFFF wraps to 16'h0000.
- Lookup always reads pre-edge table contents. An update in the same cycle does not affect that cycle's nextPC.
- Update occurs at posedge clk when reset_n=1 and forcePC=1. Entry is indexed by EX_PC[IDX_BITS-1:0]; etag = EX_PC tag.
  - Redirect not taken (forcePCdata == EX_PC+1):
    - If the entry is valid and its tag matches etag, ctr decrements, saturating at 0.
    - Otherwise no change.
  - Redirect taken (forcePCdata != EX_PC+1), entry valid with matching tag:
    - target <= forcePCdata.
    - ctr increments, saturating at 3.
  - Redirect taken, entry invalid or tag mismatch (allocate/replace):
    - valid <= 1, tag <= etag, target <= forcePCdata, ctr <= 2 (weakly taken).
- forcePC=0: no state change.
- forcePC with X/Z value is treated as 0.
- Reset: at posedge clk with reset_n=0, all valid bits clear and all ctr are set to 1.
  - Reset has priority over a simultaneous forcePC update.
  - After reset, nextPC = PC + 1 for every PC.
  - Target and tag values are don't-care after reset.
- Initial simulation state equals the reset state.
- nextPC carries no register and has zero latency. A changed PC is reflected in the same delta.
- Aliasing: a different PC with the same index and a different tag misses, so nextPC = PC + 1.

Test Plan:
- Reset, PC=16'h0005 -> nextPC=16'h0006. Then PC=16'hFFFF -> nextPC=16'h0000.
- forcePC=1, EX_PC=16'h0010, forcePCdata=16'h0040 for one edge; then PC=16'h0010 -> nextPC=16'h0040, ctr=2.
- Continuing: forcePC=1, EX_PC=16'h0010, forcePCdata=16'h0011 once -> ctr=1, so PC=16'h0010 gives nextPC=16'h0011. Two taken redirects to 16'h0050 -> nextPC=16'h0050, ctr=3.
- Alias: after entry for 16'h0010 exists, PC=16'h0110 -> nextPC=16'h0111. Taken redirect EX_PC=16'h0110, forcePCdata=16'h0200 -> entry replaced; PC=16'h0010 gives 16'h0011, PC=16'h0110 gives 16'h0200.
- Same-cycle: PC=16'h0020 while forcePC trains EX_PC=16'h0020 to 16'h0030 -> nextPC=16'h0021 that cycle, 16'h0030 after the edge.
- Reset with reset_n=0 and forcePC=1 on the same edge -> all entries invalid; PC=16'h0010 gives nextPC=16'h0011.
